// File: rtl/uart_tx_word_scheduler_pkg.sv
// Shared UART definitions: transmitter byte width and the word scheduler's one-hot state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
// Ports: none (package).
package uart_tx_word_scheduler_pkg;

  // Byte width of the shared UART transmitter.
  localparam int NB_DATA = 8;

  // The scheduler FSM is one-hot, so each state owns exactly one bit.
  localparam int NB_STATE = 4;

  typedef enum logic [NB_STATE-1:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    WAIT  = 4'b0100,
    DONE  = 4'b1000
  } sched_state_e;

endpackage

// File: rtl/uart_tx_word_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter: on a tie, the requester that was not served last wins.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; enable_i gates the grant so the owner decides when a decision may be taken.
// Ports:
//   req0_i, req1_i   request lines
//   last_grant_i     index of the requester served most recently
//   enable_i         allow a grant this cycle
//   grant_vld_o      a grant is issued
//   grant_idx_o      index of the granted requester (meaningful with grant_vld_o)
module uart_tx_word_scheduler_rr_arbiter_2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  input  logic enable_i,
  output logic grant_vld_o,
  output logic grant_idx_o
);

  always_comb begin
    grant_vld_o = enable_i & (req0_i | req1_i);
    if (req0_i & req1_i) begin
      grant_idx_o = ~last_grant_i;
    end else begin
      // Single requester: index is 1 only when requester 1 is the one asking.
      grant_idx_o = req1_i;
    end
  end

endmodule

// File: rtl/uart_tx_word_scheduler.sv
// Shares one UART transmitter between two word requesters, sending the granted word LSB byte first.
// Latency: request in IDLE -> tx_start next cycle; done -> next tx_start next cycle; last done -> ack next cycle.
// Backpressure: requesters hold their request until acked; each byte waits for the transmitter's done pulse.
// Ports:
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_req0/i_word0           requester 0 request and word (word sampled in the grant cycle)
//   i_req1/i_word1           requester 1 request and word
//   i_tx_done                transmitter finished the current byte (1-cycle pulse)
//   o_tx_start/o_tx_data     start pulse and byte for the transmitter
//   o_ack0/o_ack1            1-cycle pulse when the respective word has been fully sent
//   o_busy, o_grant          scheduler active, index of the requester being served
module uart_tx_word_scheduler #(
  parameter int NB_DATA = uart_tx_word_scheduler_pkg::NB_DATA,
  parameter int NB_WORD = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_req0,
  input  logic [NB_WORD-1:0] i_word0,
  input  logic               i_req1,
  input  logic [NB_WORD-1:0] i_word1,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_ack0,
  output logic               o_ack1,
  output logic               o_busy,
  output logic               o_grant
);

  import uart_tx_word_scheduler_pkg::*;

  localparam int N_BYTES = NB_WORD / NB_DATA;
  localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  sched_state_e       state_q, state_d;
  logic [NB_WORD-1:0] word_q, word_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;

  logic               tx_start_q, tx_start_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               busy_q, busy_d;

  logic               arb_vld;
  logic               arb_idx;

  uart_tx_word_scheduler_rr_arbiter_2 u_arb (
    .req0_i       (i_req0),
    .req1_i       (i_req1),
    .last_grant_i (last_grant_q),
    .enable_i     (state_q == IDLE),
    .grant_vld_o  (arb_vld),
    .grant_idx_o  (arb_idx)
  );

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          word_d  = arb_idx ? i_word1 : i_word0;
          cnt_d   = '0;
          grant_d = arb_idx;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (i_tx_done) begin
          // Compare before incrementing so the counter never needs to wrap.
          if (cnt_q == NB_CNT'(N_BYTES - 1)) begin
            state_d = DONE;
          end else begin
            word_d  = word_q >> NB_DATA;
            cnt_d   = cnt_q + NB_CNT'(1);
            state_d = START;
          end
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    tx_start_d = (state_d == START);
    tx_data_d  = (state_d == START) ? word_d[NB_DATA-1:0] : tx_data_q;
    ack0_d     = (state_d == DONE) & ~grant_d;
    ack1_d     = (state_d == DONE) &  grant_d;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      word_q       <= '0;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      // Pretend requester 1 went last so requester 0 wins the first tie.
      last_grant_q <= 1'b1;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_ack0     = ack0_q;
  assign o_ack1     = ack1_q;
  assign o_busy     = busy_q;
  assign o_grant    = grant_q;

endmodule

// File: tb/tb_uart_tx_word_scheduler.sv
module tb_uart_tx_word_scheduler;

  logic        i_clock;
  logic        i_reset;
  logic        i_req0;
  logic [31:0] i_word0;
  logic        i_req1;
  logic [31:0] i_word1;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_ack0;
  logic        o_ack1;
  logic        o_busy;
  logic        o_grant;

  int n_vec = 0;
  int n_err = 0;
  bit last_ref;  // reference: requester served most recently

  uart_tx_word_scheduler #(.NB_DATA(8), .NB_WORD(32)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_req0     (i_req0),
    .i_word0    (i_word0),
    .i_req1     (i_req1),
    .i_word1    (i_word1),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_ack0     (o_ack0),
    .o_ack1     (o_ack1),
    .o_busy     (o_busy),
    .o_grant    (o_grant)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic cyc();
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_req0 = 1'b0; i_req1 = 1'b0; i_tx_done = 1'b0;
    i_word0 = '0; i_word1 = '0;
    cyc(); cyc();
    i_reset = 1'b0;
    last_ref = 1'b1;
  endtask

  // Round-robin rule: on a tie serve the one not served last, else whoever asks.
  function automatic bit rr_pick(bit p0, bit p1, bit last);
    if (p0 && p1) return !last;
    return p1;
  endfunction

  // Acts as the UART transmitter for one whole word and collects what the DUT sent.
  // bad counts protocol timing violations seen along the way.
  task automatic xfer(input int drop_b, output logic [31:0] w, output logic [1:0] ack,
                      output logic g, output int bad);
    int n;
    bad = 0; w = '0; ack = '0; g = 1'b0; n = 0;
    while (o_tx_start !== 1'b1 && n < 20) begin cyc(); n++; end
    if (o_tx_start !== 1'b1) begin bad = 1; return; end
    for (int b = 0; b < 4; b++) begin
      w[8*b +: 8] = o_tx_data;
      if (o_busy !== 1'b1) bad++;
      n = $urandom_range(2, 5);
      for (int k = 0; k < n; k++) begin
        if (b == drop_b && k == 1) begin i_req0 = 1'b0; i_req1 = 1'b0; end
        cyc();
        if (o_tx_start !== 1'b0 || o_ack0 !== 1'b0 || o_ack1 !== 1'b0 || o_busy !== 1'b1) bad++;
      end
      i_tx_done = 1'b1; cyc(); i_tx_done = 1'b0;
      if (b < 3) begin
        if (o_tx_start !== 1'b1 || o_ack0 !== 1'b0 || o_ack1 !== 1'b0) bad++;
      end else begin
        ack = {o_ack1, o_ack0};
        g   = o_grant;
        if (o_tx_start !== 1'b0 || o_busy !== 1'b1) bad++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({o_tx_start, o_tx_data, o_ack0, o_ack1, o_busy, o_grant} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs got start=%b data=%h ack0=%b ack1=%b busy=%b grant=%b want all 0",
               o_tx_start, o_tx_data, o_ack0, o_ack1, o_busy, o_grant);
    end
    repeat (3) cyc();
    n_vec++;
    if ({o_tx_start, o_busy} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle_hold got start=%b busy=%b want 0 0", o_tx_start, o_busy);
    end
  endtask

  task automatic test_single();
    logic [31:0] w; logic [1:0] a; logic g; int bad;
    do_reset();
    i_req0 = 1'b1; i_word0 = 32'h11223344;
    cyc();
    n_vec++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h44 || o_busy !== 1'b1) begin
      n_err++; $display("FAIL single_latency got start=%b data=%h busy=%b want 1 44 1", o_tx_start, o_tx_data, o_busy);
    end
    xfer(-1, w, a, g, bad);
    i_req0 = 1'b0;
    last_ref = 1'b0;
    n_vec++;
    if (w !== 32'h11223344) begin n_err++; $display("FAIL single_bytes got %h want 11223344", w); end
    n_vec++;
    if (a !== 2'b01 || g !== 1'b0) begin n_err++; $display("FAIL single_ack got ack=%b grant=%b want 01 0", a, g); end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL single_timing got %0d violations want 0", bad); end
    cyc();
    n_vec++;
    if ({o_busy, o_ack0, o_ack1, o_tx_start} !== 4'b0) begin
      n_err++; $display("FAIL single_back_idle got busy=%b ack0=%b ack1=%b start=%b want 0", o_busy, o_ack0, o_ack1, o_tx_start);
    end
  endtask

  // Both requesters asserted together; each drops its request once acked.
  task automatic test_contend();
    logic [31:0] w; logic [1:0] a; logic g; int bad; bit p0, p1, exp;
    do_reset();
    p0 = 1'b1; p1 = 1'b1;
    i_word0 = 32'hAAAAAAAA; i_word1 = 32'h55555555;
    i_req0 = p0; i_req1 = p1;
    for (int i = 0; i < 4; i++) begin
      exp = rr_pick(p0, p1, last_ref);
      xfer(-1, w, a, g, bad);
      n_vec++;
      if (w !== (exp ? i_word1 : i_word0) || a !== (exp ? 2'b10 : 2'b01) || g !== exp || bad !== 0) begin
        n_err++;
        $display("FAIL contend_word%0d got word=%h ack=%b grant=%b bad=%0d want word=%h ack=%b grant=%b bad=0",
                 i, w, a, g, bad, exp ? i_word1 : i_word0, exp ? 2'b10 : 2'b01, exp);
      end
      last_ref = exp;
      if (exp) p1 = 1'b0; else p0 = 1'b0;
      if (i == 1) begin
        p0 = 1'b1; p1 = 1'b1; i_word0 = $urandom; i_word1 = $urandom;
      end
      i_req0 = p0; i_req1 = p1;
    end
    cyc();
  endtask

  // Both requesters always have another word ready; service must alternate.
  task automatic test_back_to_back();
    logic [31:0] w; logic [1:0] a; logic g; int bad; bit exp; bit prev;
    do_reset();
    i_word0 = $urandom; i_word1 = $urandom;
    i_req0 = 1'b1; i_req1 = 1'b1;
    prev = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp = rr_pick(1'b1, 1'b1, last_ref);
      xfer(-1, w, a, g, bad);
      n_vec++;
      if (w !== (exp ? i_word1 : i_word0) || g !== exp || g === prev || a !== (exp ? 2'b10 : 2'b01) || bad !== 0) begin
        n_err++;
        $display("FAIL rr_word%0d got word=%h grant=%b ack=%b bad=%0d want word=%h grant=%b",
                 i, w, g, a, bad, exp ? i_word1 : i_word0, exp);
      end
      prev = exp;
      last_ref = exp;
      if (exp) i_word1 = $urandom; else i_word0 = $urandom;
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    cyc();
  endtask

  task automatic test_spurious_done();
    logic [31:0] w; bit ok;
    do_reset();
    for (int k = 0; k < 3; k++) begin i_tx_done = 1'b1; cyc(); end
    i_tx_done = 1'b0;
    n_vec++;
    if ({o_tx_start, o_ack0, o_ack1, o_busy} !== 4'b0) begin
      n_err++; $display("FAIL spurious_idle got start=%b ack0=%b ack1=%b busy=%b want 0", o_tx_start, o_ack0, o_ack1, o_busy);
    end
    w = $urandom;
    i_word0 = w; i_req0 = 1'b1;
    cyc();
    n_vec++;
    if (o_tx_start !== 1'b1 || o_tx_data !== w[7:0]) begin
      n_err++; $display("FAIL spurious_first_start got start=%b data=%h want 1 %h", o_tx_start, o_tx_data, w[7:0]);
    end
    // Done pulse while the scheduler sits in START must not advance the byte.
    i_tx_done = 1'b1; cyc(); i_tx_done = 1'b0;
    ok = (o_tx_start === 1'b0) && (o_busy === 1'b1);
    repeat (3) begin
      cyc();
      if (o_tx_start !== 1'b0 || o_ack0 !== 1'b0 || o_ack1 !== 1'b0 || o_busy !== 1'b1) ok = 1'b0;
    end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL spurious_start got extra activity want none (start=%b busy=%b)", o_tx_start, o_busy); end
    for (int b = 1; b <= 4; b++) begin
      i_tx_done = 1'b1; cyc(); i_tx_done = 1'b0;
      if (b < 4) begin
        n_vec++;
        if (o_tx_start !== 1'b1 || o_tx_data !== w[8*b +: 8]) begin
          n_err++; $display("FAIL spurious_byte%0d got start=%b data=%h want 1 %h", b, o_tx_start, o_tx_data, w[8*b +: 8]);
        end
        cyc();
      end else begin
        n_vec++;
        if ({o_ack1, o_ack0} !== 2'b01) begin
          n_err++; $display("FAIL spurious_ack got %b want 01", {o_ack1, o_ack0});
        end
      end
    end
    i_req0 = 1'b0;
    last_ref = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [31:0] w; logic [1:0] a; logic g; int bad;
    do_reset();
    i_word0 = 32'h11223344; i_req0 = 1'b1;
    cyc();                                  // byte 0 start
    cyc();                                  // waiting on byte 0
    i_tx_done = 1'b1; cyc(); i_tx_done = 1'b0;
    n_vec++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h33) begin
      n_err++; $display("FAIL midreset_second_byte got start=%b data=%h want 1 33", o_tx_start, o_tx_data);
    end
    cyc();                                  // waiting on byte 1
    i_reset = 1'b1; cyc();
    n_vec++;
    if ({o_tx_start, o_tx_data, o_ack0, o_ack1, o_busy, o_grant} !== 13'd0) begin
      n_err++; $display("FAIL midreset_outputs got start=%b data=%h ack0=%b ack1=%b busy=%b grant=%b want all 0",
                        o_tx_start, o_tx_data, o_ack0, o_ack1, o_busy, o_grant);
    end
    i_reset = 1'b0;
    last_ref = 1'b1;
    xfer(-1, w, a, g, bad);
    i_req0 = 1'b0;
    last_ref = 1'b0;
    n_vec++;
    if (w !== 32'h11223344 || a !== 2'b01 || bad !== 0) begin
      n_err++; $display("FAIL midreset_resend got word=%h ack=%b bad=%0d want 11223344 01 0", w, a, bad);
    end
    cyc();
  endtask

  task automatic test_drop_req();
    logic [31:0] w; logic [1:0] a; logic g; int bad; logic [31:0] exp_w; bit quiet;
    do_reset();
    exp_w = $urandom;
    i_word1 = exp_w; i_req1 = 1'b1;
    xfer(1, w, a, g, bad);
    n_vec++;
    if (w !== exp_w || a !== 2'b10 || g !== 1'b1 || bad !== 0) begin
      n_err++; $display("FAIL drop_complete got word=%h ack=%b grant=%b bad=%0d want %h 10 1 0", w, a, g, bad, exp_w);
    end
    quiet = 1'b1;
    repeat (4) begin
      cyc();
      if (o_tx_start !== 1'b0 || o_ack0 !== 1'b0 || o_ack1 !== 1'b0 || o_busy !== 1'b0) quiet = 1'b0;
    end
    n_vec++;
    if (!quiet) begin n_err++; $display("FAIL drop_no_resend got activity after ack want idle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contend();
    test_back_to_back();
    test_spurious_done();
    test_reset_mid();
    test_drop_req();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_word_scheduler.md
Name: uart_tx_word_scheduler

Overview:
Shares the single UART transmitter between two requesters, e.g. the debug unit's register/memory dump path (req 0) and its status/ack path (req 1). Each requester hands over one NB_WORD-bit word. The block arbitrates round-robin, latches the granted word, and sends it byte by byte, least-significant byte first. For each byte it pulses the transmitter's start input and waits for its done pulse. When the last byte completes, it acknowledges the granted requester.

Parameters:
NB_DATA, 8, transmitter byte width
NB_WORD, 32, requester word width; must be an integer multiple of NB_DATA
N_BYTES, NB_WORD/NB_DATA, bytes per word (derived localparam, not overridable)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_req0  in  1  requester 0 has a word pending; held high until o_ack0
i_word0  in  NB_WORD  requester 0 word; sampled only in the grant cycle
i_req1  in  1  requester 1 has a word pending
i_word1  in  NB_WORD  requester 1 word
i_tx_done  in  1  one-cycle pulse from the transmitter: byte's stop bit finished
o_tx_start  out  1  one-cycle pulse to the transmitter's start input
o_tx_data  out  NB_DATA  byte to send; valid while o_tx_start=1
o_ack0  out  1  one-cycle pulse: requester 0 word fully sent
o_ack1  out  1  one-cycle pulse: requester 1 word fully sent
o_busy  out  1  high in every state except IDLE
o_grant  out  1  index of the requester currently being served; meaningful while o_busy

Behaviour:
- All outputs are registered. Reset values:
  - o_tx_start=0, o_tx_data=0, o_ack0=0, o_ack1=0, o_busy=0, o_grant=0.
  - Internally: state=IDLE, last_grant=1 (so req0 wins the first tie), byte_cnt=0, word_reg=0.
- One-hot FSM with states IDLE, START, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant the requester other than last_grant.
  - On grant: word_reg<=selected word, byte_cnt<=0, grant<=index, go to START.
- START (exactly 1 cycle):
  - o_tx_start=1, o_tx_data=word_reg[NB_DATA-1:0].
  - Go to WAIT.
- WAIT: on i_tx_done:
  - byte_cnt==N_BYTES-1: go to DONE.
  - Otherwise: word_reg<=word_reg>>NB_DATA, byte_cnt<=byte_cnt+1, go to START.
- DONE (exactly 1 cycle):
  - o_ack[grant]=1, last_grant<=grant, go to IDLE.
  - The requester updates or drops its request at the edge ending DONE, so IDLE never re-sends a stale word.
- Latency:
  - Request seen in IDLE at cycle 0 -> o_tx_start high at cycle 1.
  - Done pulse at cycle t -> next o_tx_start at t+1 (transmitter is back in idle by then).
  - Last done at cycle t -> ack at t+1, new grant decision at t+2.
- i_tx_done outside WAIT is ignored.
- A requester dropping its request mid-transfer is ignored: the latched word completes and is still acknowledged.
- The non-granted request stays pending without loss. It is served next, after at most one word from the other requester when both contend continuously.
- byte_cnt width is clog2(N_BYTES), minimum 1. Wrap never occurs because the count is compared before incrementing.
- Reset mid-operation: all state returns to reset values immediately. The in-flight word is dropped and no ack is issued. The transmitter shares i_reset.
- Only one o_tx_start is ever outstanding. No new start is issued until the matching done has been received.

Decomposition:
- Shared UART package:
  - NB_DATA.
  - Scheduler state localparams: IDLE=4'b0001, START=4'b0010, WAIT=4'b0100, DONE=4'b1000.
  - NB_STATE=4.
- Sub-module rr_arbiter_2:
  - Inputs: two requests, last_grant, enable.
  - Outputs: grant valid and grant index.
  - Purely combinational.
  - Reused by the future receive-side dispatcher.

Test Plan:
1. After reset, i_req0=1 with i_word0=32'h11223344. Expect:
   - o_tx_start pulses with o_tx_data 8'h44, 8'h33, 8'h22, 8'h11 in order, each pulse the cycle after the previous i_tx_done.
   - o_ack0 pulses once, 1 cycle after the 4th done.
   - o_busy is high throughout.
2. i_req0 and i_req1 asserted in the same cycle, word0=32'hAAAAAAAA, word1=32'h55555555. Expect:
   - word0 bytes are sent first, then o_ack0.
   - word1 bytes follow, then o_ack1.
   - A second simultaneous request pair after that grants req0 again.
3. Both requesters continuously re-requesting for 4 words. Expect grants alternating 0,1,0,1, with no requester served twice in a row.
4. Spurious i_tx_done in IDLE and during START. Expect no state change, no extra o_tx_start and no ack.
5. i_reset asserted in WAIT after the 2nd byte. Expect:
   - All outputs 0 on the next cycle, no o_ack.
   - With req0 still high, a full resend of the word restarts from byte 8'h44.
6. Requester drops i_req1 during WAIT of its word. Expect all 4 bytes still sent and o_ack1 pulsed once.
